// File: rtl/sky130_fd_io__amux_pkg.sv
// Shared types, default sizing and the round-robin pick used by the
// analog mux bus arbiter channels.
package sky130_fd_io__amux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONN,
    ST_BREAK
  } amux_state_e;

  localparam int NREQ_DEF    = 4;
  localparam int BBM_CYC_DEF = 4;
  localparam int CW_DEF      = 8;
  localparam int MAXREQ      = 16;

  // Scan n requesters starting at ptr (ptr < n), wrapping at n; first set bit wins.
  function automatic void rr_pick(input  logic [MAXREQ-1:0] req,
                                  input  int                ptr,
                                  input  int                n,
                                  output logic              vld,
                                  output int                idx);
    int j;
    vld = 1'b0;
    idx = 0;
    for (int i = 0; i < MAXREQ; i++) begin
      j = ptr + i;
      if (j >= n) j = j - n;
      if ((i < n) && !vld && req[j[3:0]]) begin
        vld = 1'b1;
        idx = j;
      end
    end
  endfunction

endpackage

// File: rtl/sky130_fd_io__amux_chan.sv
// One bus channel: round-robin grant, hold while the owner requests,
// then a fixed break interval with every switch open.
module sky130_fd_io__amux_chan
  import sky130_fd_io__amux_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int BBM_CYC = BBM_CYC_DEF,
  parameter int CW      = CW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            hold_off_i,
  input  logic [NREQ-1:0] req_i,
  output logic [NREQ-1:0] gnt_o,
  output logic            busy_o
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  amux_state_e     state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            win_vld;
  int              win_idx;
  logic [PW-1:0]   win;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    rr_pick(MAXREQ'(req_i), int'(ptr_q), NREQ, win_vld, win_idx);
    win     = PW'(win_idx);
    case (state_q)
      ST_IDLE: begin
        gnt_d = '0;
        if (!hold_off_i && win_vld) begin
          gnt_d   = NREQ'(1) << win;
          owner_d = win;
          state_d = ST_CONN;
          ptr_d   = (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);
        end
      end
      ST_CONN: begin
        // No preemption: only the owner's own release or HOLD_OFF ends the connection.
        if (hold_off_i || !req_i[owner_q]) begin
          gnt_d   = '0;
          cnt_d   = CW'(BBM_CYC - 1);
          state_d = ST_BREAK;
        end
      end
      ST_BREAK: begin
        gnt_d = '0;
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      default: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign gnt_o  = gnt_q;
  assign busy_o = busy_q;

endmodule

// File: rtl/sky130_fd_io__amux_arbiter.sv
// Arbiter for AMUXBUS_A/B: two independent channels sharing HOLD_OFF.
module sky130_fd_io__amux_arbiter
  import sky130_fd_io__amux_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int BBM_CYC = BBM_CYC_DEF,
  parameter int CW      = CW_DEF
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic            HOLD_OFF,
  input  logic [NREQ-1:0] REQ_A,
  input  logic [NREQ-1:0] REQ_B,
  output logic [NREQ-1:0] GNT_A,
  output logic [NREQ-1:0] GNT_B,
  output logic            BUSY_A,
  output logic            BUSY_B
);

  sky130_fd_io__amux_chan #(
    .NREQ(NREQ), .BBM_CYC(BBM_CYC), .CW(CW)
  ) u_chan_a (
    .clk(CLK), .rst_n(RESET_N), .hold_off_i(HOLD_OFF),
    .req_i(REQ_A), .gnt_o(GNT_A), .busy_o(BUSY_A)
  );

  sky130_fd_io__amux_chan #(
    .NREQ(NREQ), .BBM_CYC(BBM_CYC), .CW(CW)
  ) u_chan_b (
    .clk(CLK), .rst_n(RESET_N), .hold_off_i(HOLD_OFF),
    .req_i(REQ_B), .gnt_o(GNT_B), .busy_o(BUSY_B)
  );

endmodule

// File: tb/tb_sky130_fd_io__amux_arbiter.sv
// Directed scoreboard bench for the analog mux bus arbiter (NREQ=4, BBM_CYC=4).
module tb_sky130_fd_io__amux_arbiter;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       HOLD_OFF = 1'b0;
  logic [3:0] REQ_A = '0, REQ_B = '0;
  logic [3:0] GNT_A, GNT_B;
  logic       BUSY_A, BUSY_B;

  int checks = 0;
  int errors = 0;

  logic [9:0] exp_q[$];
  string      tag_q[$];

  sky130_fd_io__amux_arbiter #(.NREQ(4), .BBM_CYC(4), .CW(8)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .HOLD_OFF(HOLD_OFF),
    .REQ_A(REQ_A), .REQ_B(REQ_B),
    .GNT_A(GNT_A), .GNT_B(GNT_B), .BUSY_A(BUSY_A), .BUSY_B(BUSY_B)
  );

  always #5 CLK = ~CLK;

  function automatic logic [9:0] pack_obs();
    return {GNT_A, GNT_B, BUSY_A, BUSY_B};
  endfunction

  task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed ga=%b gb=%b ba=%b bb=%b expected ga=%b gb=%b ba=%b bb=%b",
             tag, obs[9:6], obs[5:2], obs[1], obs[0], expv[9:6], expv[5:2], expv[1], expv[0]);
    end
  endtask

  task automatic check_onehot(input string tag);
    checks++;
    assert ($onehot0(GNT_A) && $onehot0(GNT_B)) else begin
      errors++;
      $error("FAIL %s_onehot0: observed ga=%b gb=%b expected at most one bit set each",
             tag, GNT_A, GNT_B);
    end
  endtask

  // Drive inputs on the falling edge, expect the registered result after the next rising edge.
  task automatic step(input logic [3:0] ra, input logic [3:0] rb, input logic h,
                      input logic [3:0] ga, input logic [3:0] gb,
                      input logic ba, input logic bb, input string tag);
    logic [9:0] e;
    string t;
    @(negedge CLK);
    REQ_A = ra; REQ_B = rb; HOLD_OFF = h;
    exp_q.push_back({ga, gb, ba, bb});
    tag_q.push_back(tag);
    @(posedge CLK);
    #1;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check(t, pack_obs(), e);
    check_onehot(t);
  endtask

  task automatic do_reset(input string tag);
    @(negedge CLK);
    RESET_N = 1'b0; REQ_A = '0; REQ_B = '0; HOLD_OFF = 1'b0;
    #1;
    check(tag, pack_obs(), 10'b0);
    @(posedge CLK);
    @(negedge CLK);
    RESET_N = 1'b1;
  endtask

  initial begin
    // Reset state and basic grant
    repeat (2) @(posedge CLK);
    #1;
    check("reset_state", pack_obs(), 10'b0);
    @(negedge CLK);
    RESET_N = 1'b1;
    step(4'b0100, 4'b0000, 1'b0, 4'b0100, 4'b0000, 1'b1, 1'b0, "basic_grant");
    step(4'b0100, 4'b0000, 1'b0, 4'b0100, 4'b0000, 1'b1, 1'b0, "basic_hold");

    // Break-before-make: owner 2 releases while pad 1 is requesting
    step(4'b0110, 4'b0000, 1'b0, 4'b0100, 4'b0000, 1'b1, 1'b0, "bbm_no_preempt");
    step(4'b0010, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, "bbm_k");
    for (int i = 1; i <= 3; i++)
      step(4'b0010, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, $sformatf("bbm_k%0d", i));
    step(4'b0010, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, "bbm_k4_idle");
    step(4'b0010, 4'b0000, 1'b0, 4'b0010, 4'b0000, 1'b1, 1'b0, "bbm_k5_grant");

    // Round-robin fairness from pointer 0
    do_reset("rr_reset");
    for (int n = 0; n < 5; n++) begin
      logic [3:0] w;
      w = 4'b0001 << (n % 4);
      step(4'b1111, 4'b0000, 1'b0, w, 4'b0000, 1'b1, 1'b0, $sformatf("rr_grant%0d", n));
      step(4'b1111 & ~w, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, $sformatf("rr_drop%0d", n));
      for (int i = 0; i < 3; i++)
        step(4'b1111, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, $sformatf("rr_brk%0d_%0d", n, i));
      step(4'b1111, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, $sformatf("rr_idle%0d", n));
    end

    // HOLD_OFF on bus B
    do_reset("hold_reset");
    step(4'b0000, 4'b0010, 1'b0, 4'b0000, 4'b0010, 1'b0, 1'b1, "hold_grant");
    step(4'b0000, 4'b0010, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1, "hold_open");
    for (int i = 0; i < 3; i++)
      step(4'b0000, 4'b0010, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1, $sformatf("hold_brk%0d", i));
    for (int i = 0; i < 16; i++)
      step(4'b0000, 4'b0010, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, $sformatf("hold_idle%0d", i));
    step(4'b0000, 4'b0010, 1'b0, 4'b0000, 4'b0010, 1'b0, 1'b1, "hold_regrant");

    // Independence of A and B
    do_reset("ind_reset");
    step(4'b0001, 4'b0001, 1'b0, 4'b0001, 4'b0001, 1'b1, 1'b1, "ind_both");
    step(4'b0000, 4'b0001, 1'b0, 4'b0000, 4'b0001, 1'b1, 1'b1, "ind_rel_a");
    for (int i = 0; i < 3; i++)
      step(4'b0000, 4'b0001, 1'b0, 4'b0000, 4'b0001, 1'b1, 1'b1, $sformatf("ind_brk%0d", i));
    step(4'b0000, 4'b0001, 1'b0, 4'b0000, 4'b0001, 1'b0, 1'b1, "ind_a_idle");

    // Asynchronous reset in the middle of BREAK
    do_reset("async_pre_reset");
    step(4'b1000, 4'b0000, 1'b0, 4'b1000, 4'b0000, 1'b1, 1'b0, "async_grant");
    step(4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, "async_brk0");
    step(4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, "async_brk1");
    @(negedge CLK);
    #2;
    RESET_N = 1'b0;
    #1;
    check("async_reset_immediate", pack_obs(), 10'b0);
    @(posedge CLK);
    #2;
    RESET_N = 1'b1;
    step(4'b1000, 4'b0000, 1'b0, 4'b1000, 4'b0000, 1'b1, 1'b0, "async_regrant");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
